rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource (bus/datapath slot) between N requesters.
//  A one-hot priority ring rotates past each winner, so every pending requester is served within N grants.
//  A hold counter caps the tenure of any grant while others wait.

---
 rtl/rr_arbiter_pkg.sv | 10 +
 rtl/rr_arbiter_pick.sv | 24 ++
 rtl/rr_arbiter.sv | 103 ++++++++++
 tb/tb_rr_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter.
// FSM state encoding used by rr_arbiter.
package rr_arbiter_pkg;

  typedef enum logic {
    RR_IDLE = 1'b0,
    RR_BUSY = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_pick: rotating-priority one-hot picker.
// req/ptr (one-hot top priority) -> gnt one-hot winner, 0 if none.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dmask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Low copy keeps only bits at or above ptr; the high copy
  // supplies the wrapped-around candidates.
  assign dbl    = {req, req};
  assign dmask  = {{N{1'b1}}, ~(ptr - N'(1))};
  assign masked = dbl & dmask;
  assign first  = masked & (~masked + (2*N)'(1));
  assign gnt    = first[N-1:0] | first[2*N-1:N];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, N requesters, hold-capped tenure.
// clk/reset/en in; req[N] in; gnt[N], gnt_vld, gnt_idx out (registered).
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAXHOLD = 8,
  localparam int IW     = $clog2(N),
  localparam int HW     = $clog2(MAXHOLD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  rr_state_t     state;
  logic [N-1:0]  ptr;
  logic [HW-1:0] hold;

  logic [N-1:0]  rot;
  logic [N-1:0]  others;
  logic [N-1:0]  pick_idle;
  logic [N-1:0]  pick_hand;
  logic          owner_on;
  logic          expired;
  logic          rotate;

  function automatic logic [IW-1:0] enc(
    input logic [N-1:0] v
  );
    enc = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) enc = enc | IW'(k);
    end
  endfunction

  assign rot      = {gnt[N-2:0], gnt[N-1]};
  assign others   = req & ~gnt;
  assign owner_on = |(req & gnt);
  assign expired  = (hold == HW'(MAXHOLD)) && (|others);
  assign rotate   = !owner_on || expired;

  rr_pick #(.N(N)) u_pick_idle (
    .req (req),
    .ptr (ptr),
    .gnt (pick_idle)
  );

  // Handover scan starts just past the outgoing owner,
  // which therefore lands at lowest priority.
  rr_pick #(.N(N)) u_pick_hand (
    .req (others),
    .ptr (rot),
    .gnt (pick_hand)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RR_IDLE;
      ptr     <= N'(1);
      hold    <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
    end else if (en) begin
      unique case (state)
        RR_IDLE: begin
          if (|req) begin
            gnt     <= pick_idle;
            gnt_vld <= 1'b1;
            gnt_idx <= enc(pick_idle);
            hold    <= HW'(1);
            state   <= RR_BUSY;
          end
        end
        RR_BUSY: begin
          if (rotate) begin
            ptr <= rot;
            if (|others) begin
              gnt     <= pick_hand;
              gnt_vld <= 1'b1;
              gnt_idx <= enc(pick_hand);
              hold    <= HW'(1);
            end else begin
              gnt     <= '0;
              gnt_vld <= 1'b0;
              gnt_idx <= '0;
              hold    <= '0;
              state   <= RR_IDLE;
            end
          end else if (hold != HW'(MAXHOLD)) begin
            hold <= hold + HW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter, N=4 MAXHOLD=3.
// Hand-computed grant sequences checked each cycle.
module tb_rr_arbiter;

  localparam int N       = 4;
  localparam int MAXHOLD = 3;
  localparam int IW      = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter #(
    .N       (N),
    .MAXHOLD (MAXHOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(
    input string         tag,
    input logic [N-1:0]  eg,
    input logic [IW-1:0] ei
  );
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(|eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
  endtask

  task automatic do_reset();
    req   = '0;
    en    = 1'b1;
    reset = 1'b1;
    tick();
    chk_g("rst", 4'b0000, 2'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    req   = '0;
    tick();
    tick();
    chk_g("rst0", 4'b0000, 2'd0);
    reset = 1'b0;
    repeat (5) begin
      tick();
      chk_g("idle", 4'b0000, 2'd0);
    end

    req = 4'b1111;
    tick(); chk_g("rr0", 4'b0001, 2'd0);
    req = 4'b1110;
    tick(); chk_g("rr1", 4'b0010, 2'd1);
    req = 4'b1101;
    tick(); chk_g("rr2", 4'b0100, 2'd2);
    req = 4'b1011;
    tick(); chk_g("rr3", 4'b1000, 2'd3);
    req = 4'b0111;
    tick(); chk_g("rr4", 4'b0001, 2'd0);

    do_reset();
    req = 4'b0101;
    repeat (3) begin
      tick(); chk_g("exp0", 4'b0001, 2'd0);
    end
    repeat (3) begin
      tick(); chk_g("exp2", 4'b0100, 2'd2);
    end
    tick(); chk_g("exp0b", 4'b0001, 2'd0);

    do_reset();
    req = 4'b0101;
    tick(); chk_g("frzh1", 4'b0001, 2'd0);
    tick(); chk_g("frzh2", 4'b0001, 2'd0);
    en = 1'b0;
    repeat (3) begin
      tick(); chk_g("frzh", 4'b0001, 2'd0);
    end
    en = 1'b1;
    tick(); chk_g("frzh3", 4'b0001, 2'd0);
    tick(); chk_g("frzhx", 4'b0100, 2'd2);

    do_reset();
    req = 4'b0010;
    repeat (20) begin
      tick(); chk_g("sat", 4'b0010, 2'd1);
    end

    do_reset();
    req = 4'b0001;
    tick(); chk_g("ho0", 4'b0001, 2'd0);
    req = 4'b0100;
    tick(); chk_g("ho2", 4'b0100, 2'd2);

    req = 4'b1011;
    en  = 1'b0;
    repeat (4) begin
      tick(); chk_g("frz", 4'b0100, 2'd2);
    end
    en = 1'b1;
    tick(); chk_g("resume", 4'b1000, 2'd3);

    en    = 1'b0;
    reset = 1'b1;
    tick(); chk_g("rstdom", 4'b0000, 2'd0);
    reset = 1'b0;
    en    = 1'b1;
    tick(); chk_g("ptr0", 4'b0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
